// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the instruction cache: word type, frame record, FSM states.
// The frame tag field is sized for the smallest legal cache (NSETS=2); larger caches zero-extend.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int    ICACHE_NSETS    = 16;
  localparam word_t ICACHE_BAD_WORD = 32'hbad1bad1;
  localparam int    ICACHE_TAG_MAXW = 29;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } icache_state_t;

  typedef struct packed {
    logic                       valid;
    logic [ICACHE_TAG_MAXW-1:0] tag;
    word_t                      data;
  } icache_frame_t;

endpackage

// File: rtl/icache_if.sv
// Datapath/memory-controller signal bundle for the instruction cache.
// The cache modport is the cache's view; the env modport drives it.
interface icache_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  modport cache (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport env (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame, read-only instruction cache with a two-state fill FSM.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
//
// state | meaning
// IDLE  | lookup; combinational hit, no memory request
// MISS  | iREN high, waiting for iwait low to write the frame
module icache
  import cpu_types_pkg::*;
#(
  parameter int NSETS = ICACHE_NSETS
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload
`ifdef ICACHE_STATS_EN
  ,
  output word_t hit_count,
  output word_t miss_count
`endif
);

  localparam int IDXW = $clog2(NSETS);

  icache_state_t state_q, state_d;
  logic [NSETS-1:0] valid_q, valid_d;
  logic [ICACHE_TAG_MAXW-1:0] tag_q [NSETS];
  word_t data_q [NSETS];

  logic [IDXW-1:0] idx;
  logic [ICACHE_TAG_MAXW-1:0] addr_tag;
  icache_frame_t rd_frame;
  logic hit;
  logic fill;
  logic unused_addr_bits;

  assign idx              = imemaddr[IDXW+1:2];
  assign addr_tag         = ICACHE_TAG_MAXW'(imemaddr[31:IDXW+2]);
  assign unused_addr_bits = ^imemaddr[1:0];

  always_comb begin
    rd_frame.valid = valid_q[idx];
    rd_frame.tag   = tag_q[idx];
    rd_frame.data  = data_q[idx];
  end

  assign hit = imemREN & rd_frame.valid & (rd_frame.tag == addr_tag);

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    ihit     = 1'b0;
    imemload = ICACHE_BAD_WORD;
    iREN     = 1'b0;
    iaddr    = '0;
    fill     = 1'b0;
    unique case (state_q)
      IDLE: begin
        ihit = hit;
        if (hit) imemload = rd_frame.data;
        if (imemREN && !hit) state_d = MISS;
      end
      MISS: begin
        // request is held even if imemREN drops, so the controller transaction always completes
        iREN  = 1'b1;
        iaddr = {imemaddr[31:2], 2'b00};
        if (!iwait) begin
          fill         = 1'b1;
          valid_d[idx] = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  // tag/data need no reset: a frame is only visible through its valid bit
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[idx]  <= addr_tag;
      data_q[idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  word_t hit_count_q, hit_count_d;
  word_t miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (ihit && (hit_count_q != '1)) hit_count_d = hit_count_q + 32'd1;
    if ((state_q == IDLE) && (state_d == MISS) && (miss_count_q != '1))
      miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache (NSETS=16); counter checks only when ICACHE_STATS_EN is defined.
module tb_icache;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;
  int   checks;
  int   errors;

  icache_if bus ();

`ifdef ICACHE_STATS_EN
  word_t hit_count;
  word_t miss_count;
`endif

  icache #(.NSETS(16)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (bus.imemREN),
    .imemaddr (bus.imemaddr),
    .ihit     (bus.ihit),
    .imemload (bus.imemload),
    .iREN     (bus.iREN),
    .iaddr    (bus.iaddr),
    .iwait    (bus.iwait),
    .iload    (bus.iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nRST         = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h0;
    bus.iwait    = 1'b1;
    bus.iload    = 32'h0;

    #2;
    check("rst_ihit", 32'(bus.ihit), 32'd0);
    check("rst_iren", 32'(bus.iREN), 32'd0);
    check("rst_imemload", bus.imemload, 32'hbad1bad1);
    check("rst_iaddr", bus.iaddr, 32'h0);
`ifdef ICACHE_STATS_EN
    check("rst_hitcnt", hit_count, 32'd0);
    check("rst_misscnt", miss_count, 32'd0);
`endif
    #10 nRST = 1'b1;
    step();

    // cold miss on 0x40
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0040;
    #1;
    check("cold_ihit", 32'(bus.ihit), 32'd0);
    check("cold_iren_idle", 32'(bus.iREN), 32'd0);
    check("cold_load_bad", bus.imemload, 32'hbad1bad1);
    step();
    check("miss_iren", 32'(bus.iREN), 32'd1);
    check("miss_iaddr", bus.iaddr, 32'h0000_0040);
    check("miss_ihit", 32'(bus.ihit), 32'd0);
    bus.iwait = 1'b0;
    bus.iload = 32'h2001_0005;
    step();
    bus.iwait = 1'b1;
    #1;
    check("fill_ihit", 32'(bus.ihit), 32'd1);
    check("fill_load", bus.imemload, 32'h2001_0005);
    check("fill_iren", 32'(bus.iREN), 32'd0);
    check("fill_iaddr", bus.iaddr, 32'h0);
`ifdef ICACHE_STATS_EN
    check("fill_misscnt", miss_count, 32'd1);
    check("fill_hitcnt", hit_count, 32'd0);
`endif

    // repeat hit on 0x40
    step();
    check("rehit_ihit", 32'(bus.ihit), 32'd1);
    check("rehit_iren", 32'(bus.iREN), 32'd0);
    check("rehit_load", bus.imemload, 32'h2001_0005);
`ifdef ICACHE_STATS_EN
    check("rehit_misscnt", miss_count, 32'd1);
    check("rehit_hitcnt", hit_count, 32'd1);
`endif

    // conflicting tag at the same index evicts 0x40
    bus.imemaddr = 32'h0000_0440;
    #1;
    check("conf_ihit", 32'(bus.ihit), 32'd0);
    check("conf_load_bad", bus.imemload, 32'hbad1bad1);
    step();
    check("conf_iaddr", bus.iaddr, 32'h0000_0440);
    bus.iwait = 1'b0;
    bus.iload = 32'hDEAD_BEEF;
    step();
    bus.iwait = 1'b1;
    #1;
    check("conf_fill_ihit", 32'(bus.ihit), 32'd1);
    check("conf_fill_load", bus.imemload, 32'hDEAD_BEEF);
    bus.imemaddr = 32'h0000_0040;
    #1;
    check("evicted_ihit", 32'(bus.ihit), 32'd0);
    step();
    check("evicted_iren", 32'(bus.iREN), 32'd1);
    check("evicted_iaddr", bus.iaddr, 32'h0000_0040);
    bus.iwait = 1'b0;
    bus.iload = 32'h2001_0005;
    step();
    bus.iwait = 1'b1;
    #1;
    check("refill_ihit", 32'(bus.ihit), 32'd1);
`ifdef ICACHE_STATS_EN
    check("conf_misscnt", miss_count, 32'd3);
`endif

    // long stall in MISS with imemREN dropped at cycle 3
    bus.imemaddr = 32'h0000_0084;
    step();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) bus.imemREN = 1'b0;
      #1;
      check("stall_iren", 32'(bus.iREN), 32'd1);
      check("stall_ihit", 32'(bus.ihit), 32'd0);
      step();
    end
    bus.iwait = 1'b0;
    bus.iload = 32'h1111_2222;
    step();
    bus.iwait = 1'b1;
    #1;
    check("stall_done_iren", 32'(bus.iREN), 32'd0);
    check("stall_done_ihit", 32'(bus.ihit), 32'd0);
    bus.imemREN = 1'b1;
    #1;
    check("stall_frame_ihit", 32'(bus.ihit), 32'd1);
    check("stall_frame_load", bus.imemload, 32'h1111_2222);
`ifdef ICACHE_STATS_EN
    check("stall_misscnt", miss_count, 32'd4);
`endif

    // reset in the middle of a miss
    bus.imemaddr = 32'h0000_00C4;
    step();
    check("rmiss_iren", 32'(bus.iREN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("rmiss_iren_drop", 32'(bus.iREN), 32'd0);
    check("rmiss_ihit", 32'(bus.ihit), 32'd0);
    check("rmiss_load", bus.imemload, 32'hbad1bad1);
`ifdef ICACHE_STATS_EN
    check("rmiss_hitcnt", hit_count, 32'd0);
    check("rmiss_misscnt", miss_count, 32'd0);
`endif
    bus.iwait = 1'b0;
    step();
    bus.iwait = 1'b1;
    #2 nRST = 1'b1;
    bus.imemaddr = 32'h0000_0040;
    #1;
    check("post_rst_ihit", 32'(bus.ihit), 32'd0);
    step();
    check("post_rst_iren", 32'(bus.iREN), 32'd1);
    check("post_rst_iaddr", bus.iaddr, 32'h0000_0040);
    bus.imemaddr = 32'h0000_00C4;
    #1;
    check("post_rst_c4_ihit", 32'(bus.ihit), 32'd0);
    bus.iwait = 1'b0;
    bus.iload = 32'h0BAD_C0DE;
    step();
    bus.iwait = 1'b1;
    #1;
    check("addr_change_ihit", 32'(bus.ihit), 32'd1);
    check("addr_change_load", bus.imemload, 32'h0BAD_C0DE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
